// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the memory access unit: FSM state encoding and the
// data / address / register-address widths used by the top and watchdog.
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int REG_W  = 3;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_WB   = 2'b11
  } state_e;

endpackage

// File: rtl/mem_access_unit_watchdog.sv
// ---------------------------------------------------------------------------
// mau_watchdog
// Counts cycles spent waiting on a busy memory and flags a timeout on the
// cycle the count would reach TIMEOUT_CYCLES. Only instantiated when the
// MAU_TIMEOUT_EN macro is defined.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clr         : clear the count (asserted whenever no access is waiting)
//   inc         : one more busy cycle observed this clock
//   timeout     : combinational, high when this increment hits the limit
//   count       : current count (debug visibility)
// ---------------------------------------------------------------------------
module mau_watchdog
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic             timeout,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  // Firing on the increment that reaches the limit lets the FSM abort on
  // exactly the TIMEOUT_CYCLES-th busy posedge.
  assign timeout = inc && (count_q == LIMIT_M1);
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Sequences processor loads/stores onto a data memory that may stall with
// MEM_BUSYWAIT, and writes load data back into the register file.
// Optional watchdog: define MAU_TIMEOUT_EN to abort accesses that stay busy
// for TIMEOUT_CYCLES cycles and raise a sticky ERROR.
//
// Handshake: a request (LOAD/STORE) is accepted only in IDLE, at the posedge
// where it is high; BUSYWAIT is high whenever a request is pending or an
// access is in flight, and the processor holds its PC while it is high.
// Memory side: MEM_READ/MEM_WRITE stay high until MEM_BUSYWAIT is sampled
// low at a posedge, which completes the access.
//
// Ports:
//   CLK, RESET                     : clock, synchronous active-high reset
//   LOAD, STORE                    : processor requests (STORE wins if both)
//   ADDRESS, STORE_DATA, DEST_REG  : request operands
//   BUSYWAIT                       : processor stall (combinational)
//   MEM_READ, MEM_WRITE            : memory strobes (registered)
//   MEM_ADDRESS, MEM_WRITEDATA     : latched memory address / write data
//   MEM_READDATA, MEM_BUSYWAIT     : memory response
//   RF_IN, RF_INADDRESS, RF_WRITE  : register-file write port
//   ERROR                          : sticky timeout flag (0 without watchdog)
//   dbg_state                      : current FSM state
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LOAD,
  input  logic              STORE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] STORE_DATA,
  input  logic [REG_W-1:0]  DEST_REG,
  output logic              BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic [DATA_W-1:0] RF_IN,
  output logic [REG_W-1:0]  RF_INADDRESS,
  output logic              RF_WRITE,
  output logic              ERROR,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rf_in_q, rf_in_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              rf_write_q, rf_write_d;
  logic              timeout;

`ifdef MAU_TIMEOUT_EN
  logic              error_q, error_d;
  logic [CNT_W-1:0]  wd_count;
  logic              wd_waiting;

  assign wd_waiting = (state_q == ST_RD) || (state_q == ST_WR);

  // Count is held at zero outside RD/WR, so every entry starts from zero.
  mau_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (CLK),
    .reset   (RESET),
    .clr     (!wd_waiting),
    .inc     (wd_waiting && MEM_BUSYWAIT),
    .timeout (timeout),
    .count   (wd_count)
  );

  assign error_d = error_q | timeout;
  assign ERROR   = error_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign ERROR   = 1'b0;
`endif

  // Strobes are registered, so they are computed from the next state.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rf_in_d     = rf_in_q;
    dest_d      = dest_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    rf_write_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (STORE) begin
          mem_addr_d  = ADDRESS;
          mem_wdata_d = STORE_DATA;
          mem_write_d = 1'b1;
          state_d     = ST_WR;
        end else if (LOAD) begin
          mem_addr_d = ADDRESS;
          dest_d     = DEST_REG;
          mem_read_d = 1'b1;
          state_d    = ST_RD;
        end
      end
      ST_RD: begin
        if (timeout) begin
          state_d = ST_IDLE;
        end else if (!MEM_BUSYWAIT) begin
          rf_in_d    = MEM_READDATA;
          rf_write_d = 1'b1;
          state_d    = ST_WB;
        end else begin
          mem_read_d = 1'b1;
        end
      end
      ST_WR: begin
        if (timeout || !MEM_BUSYWAIT) begin
          state_d = ST_IDLE;
        end else begin
          mem_write_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rf_in_q     <= '0;
      dest_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rf_write_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rf_in_q     <= rf_in_d;
      dest_q      <= dest_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      rf_write_q  <= rf_write_d;
    end
  end

  assign BUSYWAIT      = (state_q != ST_IDLE) || LOAD || STORE;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign RF_IN         = rf_in_q;
  assign RF_INADDRESS  = dest_q;
  assign RF_WRITE      = rf_write_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit. Register-file writes and memory
// writes are predicted into queues when stimulus is driven and checked by a
// monitor when the DUT produces them; each scenario task also checks its own
// cycle-level behaviour. Build with +define+MAU_TIMEOUT_EN to cover the
// watchdog (DUT then uses TIMEOUT_CYCLES=4).
// ---------------------------------------------------------------------------
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

`ifdef MAU_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              load, store;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] store_data;
  logic [REG_W-1:0]  dest_reg;
  logic              busywait, mem_read, mem_write, rf_write, error;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata, mem_readdata, rf_in;
  logic              mem_busywait;
  logic [REG_W-1:0]  rf_inaddress;
  state_e            dbg_state;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .CLK           (clk),
    .RESET         (reset),
    .LOAD          (load),
    .STORE         (store),
    .ADDRESS       (address),
    .STORE_DATA    (store_data),
    .DEST_REG      (dest_reg),
    .BUSYWAIT      (busywait),
    .MEM_READ      (mem_read),
    .MEM_WRITE     (mem_write),
    .MEM_ADDRESS   (mem_address),
    .MEM_WRITEDATA (mem_writedata),
    .MEM_READDATA  (mem_readdata),
    .MEM_BUSYWAIT  (mem_busywait),
    .RF_IN         (rf_in),
    .RF_INADDRESS  (rf_inaddress),
    .RF_WRITE      (rf_write),
    .ERROR         (error),
    .dbg_state     (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- scoreboard ----------------
  logic [REG_W+DATA_W-1:0]  exp_q[$];     // {dest, data} register writes
  logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];  // {addr, data} memory writes
  logic                     mem_write_prev = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      mem_write_prev = 1'b0;
    end else begin
      checks++;
      if (mem_read && mem_write) begin
        failures++;
        $display("FAIL strobes_exclusive: mem_read=%0b mem_write=%0b required not both", mem_read, mem_write);
      end
      if (rf_write) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rf_write_unexpected: rf_write=1 with dest=%0d data=%h, required 0", rf_inaddress, rf_in);
        end else begin
          logic [REG_W+DATA_W-1:0] e;
          e = exp_q.pop_front();
          if ({rf_inaddress, rf_in} !== e) begin
            failures++;
            $display("FAIL rf_write_value: got dest=%0d data=%h required dest=%0d data=%h", rf_inaddress, rf_in, e[DATA_W +: REG_W], e[DATA_W-1:0]);
          end
        end
      end
      if (mem_write && !mem_write_prev) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          failures++;
          $display("FAIL mem_write_unexpected: addr=%h data=%h", mem_address, mem_writedata);
        end else begin
          logic [ADDR_W+DATA_W-1:0] w;
          w = exp_wr_q.pop_front();
          if ({mem_address, mem_writedata} !== w) begin
            failures++;
            $display("FAIL mem_write_value: got addr=%h data=%h required addr=%h data=%h", mem_address, mem_writedata, w[DATA_W +: ADDR_W], w[DATA_W-1:0]);
          end
        end
      end
      mem_write_prev = mem_write;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 1'b0; store = 1'b0; address = '0; store_data = '0; dest_reg = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_inputs(); mem_busywait = 1'b0; mem_readdata = '0;
    tick(); tick();
    checks++;
    if ({mem_read, mem_write, rf_write, error} !== 4'b0) begin
      failures++; $display("FAIL reset_strobes: rd/wr/rfw/err=%b required 0000", {mem_read, mem_write, rf_write, error});
    end
    checks++;
    if ({mem_address, mem_writedata, rf_in, rf_inaddress} !== '0) begin
      failures++; $display("FAIL reset_data: addr=%h wdata=%h rf_in=%h rf_addr=%0d required 0", mem_address, mem_writedata, rf_in, rf_inaddress);
    end
    // Reset wins over a simultaneous request.
    load = 1'b1; store = 1'b1; tick();
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL reset_priority: state=%0d required %0d", dbg_state, ST_IDLE);
    end
    idle_inputs(); reset = 1'b0; tick();
    checks++;
    if (busywait !== 1'b0) begin
      failures++; $display("FAIL reset_busywait: busywait=%b required 0", busywait);
    end
  endtask

  task automatic test_load(input logic [ADDR_W-1:0] a, input logic [REG_W-1:0] d,
                           input logic [DATA_W-1:0] data, input int nbusy);
    int rd_cnt = 0;
    load = 1'b1; address = a; dest_reg = d; mem_busywait = 1'b1;
    #1;
    checks++;
    if (busywait !== 1'b1) begin
      failures++; $display("FAIL load_req_busywait: busywait=%b required 1", busywait);
    end
    exp_q.push_back({d, data});
    tick();
    idle_inputs(); address = ~a;
    for (int i = 0; i < nbusy; i++) begin
      if (mem_read) rd_cnt++;
      tick();
    end
    if (mem_read) rd_cnt++;
    checks++;
    if (mem_address !== a) begin
      failures++; $display("FAIL load_addr: mem_address=%h required %h", mem_address, a);
    end
    mem_busywait = 1'b0; mem_readdata = data;
    tick();
    mem_readdata = ~data;
    checks++;
    if (rd_cnt != nbusy + 1) begin
      failures++; $display("FAIL load_read_cycles: mem_read cycles=%0d required %0d", rd_cnt, nbusy + 1);
    end
    checks++;
    if ({rf_write, mem_read, busywait} !== 3'b101) begin
      failures++; $display("FAIL load_wb: rfw/rd/bw=%b required 101", {rf_write, mem_read, busywait});
    end
    tick();
    checks++;
    if ({rf_write, busywait} !== 2'b00 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL load_done: rfw/bw=%b state=%0d required 00 state 0", {rf_write, busywait}, dbg_state);
    end
  endtask

  task automatic test_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] data,
                            input int nbusy, input logic also_load);
    int wr_cnt = 0;
    store = 1'b1; load = also_load; address = a; store_data = data; mem_busywait = 1'b1;
    exp_wr_q.push_back({a, data});
    tick();
    idle_inputs(); address = ~a; store_data = ~data;
    checks++;
    if (dbg_state !== ST_WR || mem_read !== 1'b0) begin
      failures++; $display("FAIL store_entry: state=%0d mem_read=%b required state 2 mem_read 0", dbg_state, mem_read);
    end
    for (int i = 0; i < nbusy; i++) begin
      if (mem_write) wr_cnt++;
      tick();
    end
    if (mem_write) wr_cnt++;
    checks++;
    if ({mem_address, mem_writedata} !== {a, data}) begin
      failures++; $display("FAIL store_hold: addr=%h data=%h required addr=%h data=%h", mem_address, mem_writedata, a, data);
    end
    mem_busywait = 1'b0;
    tick();
    checks++;
    if (wr_cnt != nbusy + 1) begin
      failures++; $display("FAIL store_write_cycles: mem_write cycles=%0d required %0d", wr_cnt, nbusy + 1);
    end
    checks++;
    if ({mem_write, rf_write, mem_read} !== 3'b000 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL store_done: wr/rfw/rd=%b state=%0d required 000 state 0", {mem_write, rf_write, mem_read}, dbg_state);
    end
  endtask

  task automatic test_reset_mid_read();
    load = 1'b1; address = 8'h44; dest_reg = 3'd6; mem_busywait = 1'b1;
    tick();
    idle_inputs();
    tick();  // second RD cycle
    checks++;
    if (mem_read !== 1'b1) begin
      failures++; $display("FAIL midrd_in_read: mem_read=%b required 1", mem_read);
    end
    reset = 1'b1; mem_busywait = 1'b0; mem_readdata = 8'hEE;
    tick();
    checks++;
    if (dbg_state !== ST_IDLE || {mem_read, mem_write, rf_write, error} !== 4'b0) begin
      failures++; $display("FAIL midrd_abort: state=%0d rd/wr/rfw/err=%b required state 0 0000", dbg_state, {mem_read, mem_write, rf_write, error});
    end
    checks++;
    if ({mem_address, mem_writedata, rf_in, rf_inaddress} !== '0) begin
      failures++; $display("FAIL midrd_data: addr=%h wdata=%h rf_in=%h rf_addr=%0d required 0", mem_address, mem_writedata, rf_in, rf_inaddress);
    end
    reset = 1'b0; tick(); tick();
  endtask

  task automatic test_timeout();
    int rd_cnt = 0;
    load = 1'b1; address = 8'h77; dest_reg = 3'd2; mem_busywait = 1'b1;
    tick();
    idle_inputs();
`ifdef MAU_TIMEOUT_EN
    // Aborts on the 4th busy posedge; bound the wait generously.
    for (int i = 0; i < 12 && mem_read; i++) begin
      rd_cnt++;
      tick();
    end
    checks++;
    if (rd_cnt != 4 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL timeout_abort: read cycles=%0d state=%0d required 4 state 0", rd_cnt, dbg_state);
    end
    tick(); tick();
    checks++;
    if ({error, rf_write} !== 2'b10) begin
      failures++; $display("FAIL timeout_sticky: err/rfw=%b required 10", {error, rf_write});
    end
    mem_busywait = 1'b0; reset = 1'b1;
    tick();
    checks++;
    if (error !== 1'b0) begin
      failures++; $display("FAIL timeout_clear: error=%b required 0", error);
    end
    reset = 1'b0; tick();
`else
    // Without the watchdog the read waits indefinitely.
    for (int i = 0; i < 20; i++) begin
      if (mem_read) rd_cnt++;
      tick();
    end
    checks++;
    if (rd_cnt != 20 || error !== 1'b0 || dbg_state !== ST_RD) begin
      failures++; $display("FAIL no_timeout: read cycles=%0d err=%b state=%0d required 20 0 state 1", rd_cnt, error, dbg_state);
    end
    exp_q.push_back({3'd2, 8'h5A});
    mem_busywait = 1'b0; mem_readdata = 8'h5A;
    tick(); tick();
`endif
  endtask

  task automatic test_back_to_back();
    int low_cnt = 0;
    load = 1'b1; address = 8'h31; dest_reg = 3'd1; mem_busywait = 1'b0;
    exp_q.push_back({3'd1, 8'h11});
    tick();
    idle_inputs(); mem_readdata = 8'h11;
    tick();
    checks++;
    if (rf_write !== 1'b1) begin
      failures++; $display("FAIL b2b_rf_write: rf_write=%b required 1", rf_write);
    end
    tick();  // IDLE: processor released for one cycle
    if (!busywait) low_cnt++;
    store = 1'b1; address = 8'h32; store_data = 8'h99; mem_busywait = 1'b1;
    exp_wr_q.push_back({8'h32, 8'h99});
    #1;
    if (!busywait) low_cnt++;
    tick();
    idle_inputs();
    if (!busywait) low_cnt++;
    checks++;
    if (low_cnt != 1 || mem_write !== 1'b1) begin
      failures++; $display("FAIL b2b_gap: busywait low cycles=%0d mem_write=%b required 1 and 1", low_cnt, mem_write);
    end
    mem_busywait = 1'b0;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load(8'h10, 3'd3, 8'hA5, 5);
    test_store(8'h20, 8'h3C, 3, 1'b0);
    test_store(8'h05, 8'h6B, 0, 1'b1);  // LOAD+STORE: store wins
    test_load(8'hFF, 3'd7, 8'h00, 0);   // minimum latency
    test_reset_mid_read();
    test_timeout();
    test_back_to_back();
    for (int n = 0; n < 6; n++) begin
      if ($urandom_range(0, 1) == 1)
        test_load(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      else
        test_store(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'b0);
    end
    tick();
    checks++;
    if (exp_q.size() != 0 || exp_wr_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: pending rf=%0d wr=%0d required 0 0", exp_q.size(), exp_wr_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL give the MEM_BUSYWAIT cycle limit for the watchdog (8-bit count, legal 1..255).
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on posedge.
REQ-003 RESET  input  1  SHALL be the synchronous, active-high reset, sampled on posedge CLK.
REQ-004 LOAD  input  1  SHALL be the processor load request (lwd/lwi).
REQ-005 STORE  input  1  SHALL be the processor store request (swd/swi).
REQ-006 ADDRESS  input  8  SHALL be the data memory address from the ALU result.
REQ-007 STORE_DATA  input  8  SHALL be the register file OUT1 value to store.
REQ-008 DEST_REG  input  3  SHALL be the destination register address for a load.
REQ-009 BUSYWAIT  output  1  SHALL be the processor stall signal (PC hold).
REQ-010 MEM_READ, MEM_WRITE  output  1 each  SHALL be the data memory strobes.
REQ-011 MEM_ADDRESS  output  8; MEM_WRITEDATA  output  8  SHALL be registered memory address/data.
REQ-012 MEM_READDATA  input  8; MEM_BUSYWAIT  input  1  SHALL be the memory response.
REQ-013 RF_IN  output  8; RF_INADDRESS  output  3; RF_WRITE  output  1  SHALL drive the register file write port.
REQ-014 ERROR  output  1  SHALL flag a sticky memory timeout.

Function
REQ-015 FSM states SHALL be IDLE, RD, WR, WB.
REQ-016 IDLE with STORE=1 at posedge SHALL latch ADDRESS/STORE_DATA into MEM_ADDRESS/MEM_WRITEDATA and go to WR; STORE has priority when LOAD=STORE=1 (LOAD dropped).
REQ-017 IDLE with LOAD=1 only SHALL latch ADDRESS and DEST_REG and go to RD.
REQ-018 MEM_READ SHALL be 1 exactly in RD; MEM_WRITE SHALL be 1 exactly in WR.
REQ-019 RD: MEM_BUSYWAIT sampled 0 at posedge SHALL capture MEM_READDATA into RF_IN and go to WB; sampled 1 SHALL stay in RD.
REQ-020 WR: MEM_BUSYWAIT sampled 0 at posedge SHALL go to IDLE; sampled 1 SHALL stay in WR.
REQ-021 WB SHALL assert RF_WRITE for exactly one cycle with RF_INADDRESS = latched DEST_REG, then go to IDLE.
REQ-022 BUSYWAIT SHALL be combinational: 1 in IDLE when LOAD or STORE is 1, 1 in RD, WR, WB; 0 otherwise.
REQ-023 Minimum load latency: request posedge to RF_WRITE high = 2 cycles when MEM_BUSYWAIT is already 0; store = 1 cycle in WR.
REQ-024 Requests arriving outside IDLE SHALL be ignored (processor is stalled by BUSYWAIT).
REQ-025 RF_WRITE SHALL never be 1 outside WB; MEM_READ and MEM_WRITE SHALL never be 1 simultaneously.

Reset
REQ-026 RESET=1 at posedge SHALL force IDLE from any state, including mid-RD/WR/WB, aborting the access.
REQ-027 Reset values: MEM_READ=0, MEM_WRITE=0, RF_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, RF_IN=0, RF_INADDRESS=0, ERROR=0, watchdog count=0.
REQ-028 RESET SHALL take priority over every request and MEM_BUSYWAIT value in the same cycle.

Configuration
REQ-029 Macro MAU_TIMEOUT_EN defined: an 8-bit counter SHALL increment each cycle in RD or WR with MEM_BUSYWAIT=1, clear on state entry, and on reaching TIMEOUT_CYCLES SHALL abort to IDLE (no RF_WRITE) and set ERROR, sticky until RESET.
REQ-030 MAU_TIMEOUT_EN undefined: no counter logic; ERROR SHALL be constant 0; RD/WR wait indefinitely.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, RD=2'b01, WR=2'b10, WB=2'b11) and the data/address/register-address widths (8/8/3).
REQ-032 The watchdog SHALL be a sub-module mau_watchdog, instantiated only under MAU_TIMEOUT_EN.

Verification
REQ-033 Load: LOAD=1, ADDRESS=8'h10, DEST_REG=3, memory busy 5 cycles returning 8'hA5 -> MEM_READ high 6 cycles, then RF_WRITE one cycle with RF_IN=8'hA5, RF_INADDRESS=3.
REQ-034 Store: STORE=1, ADDRESS=8'h20, STORE_DATA=8'h3C, busy 3 cycles -> MEM_WRITE high 4 cycles with MEM_ADDRESS=8'h20, MEM_WRITEDATA=8'h3C; RF_WRITE stays 0.
REQ-035 LOAD=STORE=1, ADDRESS=8'h05 -> WR entered, MEM_READ never 1, RF_WRITE never 1.
REQ-036 RESET asserted in 2nd RD cycle -> next cycle IDLE, all outputs at reset values, no RF_WRITE.
REQ-037 MAU_TIMEOUT_EN, TIMEOUT_CYCLES=4, MEM_BUSYWAIT held 1 during load -> abort after 4 busy cycles, ERROR=1 until RESET, RF_WRITE=0.
REQ-038 Back-to-back: load (data 8'h11 to reg 1) then store in next IDLE cycle -> RF_WRITE once, then MEM_WRITE; BUSYWAIT low exactly one cycle between.
